water_dispenser_controller: RTL and testbench
=============================================

// Module: water_dispenser_controller
// PURPOSE
//   Keypad-driven dispenser controller: collects a decimal amount (mL) from digit switches
//   and buttons, with erase/cancel, then opens the valve and meters delivery via flow-meter
//   pulses until the target is met or the user cancels. Sits between the front-panel
//   inputs and the valve driver/display; one instance per dispensing nozzle.
// PARAMETERS
//   SWITCH_COUNT         10  number of digit switches; switch i enters digit i (i < 10)
//   MAXIMUM_DIGIT_COUNT   4  maximum digits accepted on entry
//   AMOUNT_WIDTH         14  width of amount buses; must hold 10^MAXIMUM_DIGIT_COUNT-1
//   ML_PER_PULSE         10  mL credited per flow_pulse
// PORTS
//   clock            in   1             system clock, all logic on rising edge
//   reset            in   1             synchronous, active-high
//   switches         in   SWITCH_COUNT  digit selectors, level
//   button_add       in   1             append selected digit, level
//   button_erase     in   1             remove last digit, level
//   button_ok        in   1             start dispensing, level
//   button_cancel    in   1             clear entry / abort dispense, level
//   flow_pulse       in   1             one-cycle pulse per ML_PER_PULSE delivered
//   total_amount     out  AMOUNT_WIDTH  entered target in mL
//   digit_count      out  3             digits entered (0..MAXIMUM_DIGIT_COUNT)
//   dispensed_amount out  AMOUNT_WIDTH  mL delivered in current/last dispense
//   valve_open       out  1             registered valve command
//   busy             out  1             1 while in DISPENSING
//   done             out  1             one-cycle pulse on leaving DISPENSING
//   aborted          out  1             1 if last dispense ended by cancel; held until next OK
// BEHAVIOUR
//   Reset: state=ENTRY; all outputs 0; button history regs loaded with 1 (a button held
//     through reset must be released before it acts).
//   Buttons: act on rising edge only (cur=1, prev=0); effect visible on outputs at the next
//     clock edge (1-cycle latency). Holding a button performs one action.
//   Digit select: lowest-indexed asserted switch wins; none asserted -> add ignored.
//   ENTRY, per-cycle priority cancel > ok > erase > add (one action per cycle):
//     cancel: total_amount=0, digit_count=0.
//     ok: if total_amount>0 -> DISPENSING, dispensed_amount=0, valve_open=1, busy=1,
//       aborted=0; if total_amount==0 ignored.
//     erase: if digit_count>0 -> total_amount=total_amount/10, digit_count-1; else ignored.
//     add: if digit_count<MAXIMUM_DIGIT_COUNT -> total_amount=total_amount*10+digit,
//       digit_count+1; full -> ignored (no wrap, value unchanged).
//     flow_pulse ignored in ENTRY.
//   DISPENSING:
//     flow_pulse: dispensed_amount += ML_PER_PULSE, saturating at total_amount.
//     Completion when updated dispensed_amount >= total_amount -> ENTRY next edge:
//       valve_open=0, busy=0, done=1 for one cycle, aborted=0.
//     cancel edge -> ENTRY: valve_open=0, busy=0, done=1, aborted=1; a flow_pulse in the
//       same cycle is still credited; cancel takes precedence over completion.
//     add/erase/ok ignored; total_amount and digit_count frozen.
//   On return to ENTRY total_amount/digit_count are cleared to 0; dispensed_amount holds
//     its final value until the next OK.
//   Reset in any state, including mid-dispense: valve_open=0 at the next edge, full reset.
//   Arithmetic: *10 done at AMOUNT_WIDTH bits; parameter rule guarantees no overflow.
// TESTING
//   Switches 3'b... digit 1,2,5 via add x3 -> total_amount=125, digit_count=3; erase -> 12.
//   Enter 9,9,9,9 then add digit 7 -> total_amount stays 9999, digit_count=4.
//   Enter 25, ok, 3 flow_pulses -> dispensed 10,20,25(saturated); done pulse, valve_open=0.
//   Enter 100, ok, 2 pulses, cancel coinciding with pulse -> dispensed=30, aborted=1, done=1.
//   Switches 0x000 + add; ok with total 0; buttons held 5 cycles -> single or no action.
//   reset asserted mid-dispense with button_ok held -> all outputs 0; no dispense until re-press.

Source files
------------

// File: rtl/water_dispenser_controller_if.sv
// Front-panel bundle for one dispensing nozzle: digit switches, buttons, flow meter in;
// amounts, valve command and status out.
interface water_dispenser_controller_if #(
  parameter int SWITCH_COUNT = 10,
  parameter int AMOUNT_WIDTH = 14
);
  logic [SWITCH_COUNT-1:0] switches_i;
  logic                    button_add_i;
  logic                    button_erase_i;
  logic                    button_ok_i;
  logic                    button_cancel_i;
  logic                    flow_pulse_i;
  logic [AMOUNT_WIDTH-1:0] total_amount_o;
  logic [2:0]              digit_count_o;
  logic [AMOUNT_WIDTH-1:0] dispensed_amount_o;
  logic                    valve_open_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    aborted_o;

  modport master (
    output switches_i, button_add_i, button_erase_i, button_ok_i, button_cancel_i, flow_pulse_i,
    input  total_amount_o, digit_count_o, dispensed_amount_o, valve_open_o, busy_o, done_o,
           aborted_o
  );

  modport slave (
    input  switches_i, button_add_i, button_erase_i, button_ok_i, button_cancel_i, flow_pulse_i,
    output total_amount_o, digit_count_o, dispensed_amount_o, valve_open_o, busy_o, done_o,
           aborted_o
  );
endinterface

// File: rtl/water_dispenser_controller.sv
// Keypad amount entry followed by valve-open metering of flow-meter pulses until the
// target is reached or the user cancels.
//   state        | meaning
//   ST_ENTRY     | collecting digits, valve closed
//   ST_DISPENSING| valve open, crediting flow pulses toward total_amount
module water_dispenser_controller #(
  parameter int SWITCH_COUNT        = 10,
  parameter int MAXIMUM_DIGIT_COUNT = 4,
  parameter int AMOUNT_WIDTH        = 14,
  parameter int ML_PER_PULSE        = 10
) (
  input logic                          clock_i,
  input logic                          reset_i,
  water_dispenser_controller_if.slave  pnl
);

  localparam int SUM_W = AMOUNT_WIDTH + 1;

  typedef enum logic {ST_ENTRY, ST_DISPENSING} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              btn_q;
  logic [3:0]              btn_cur;
  logic [3:0]              btn_rise;
  logic [AMOUNT_WIDTH-1:0] total_q, total_d;
  logic [2:0]              count_q, count_d;
  logic [AMOUNT_WIDTH-1:0] disp_q, disp_d;
  logic                    valve_q, valve_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;

  logic [3:0]              digit;
  logic                    digit_valid;
  logic [SUM_W-1:0]        disp_sum;
  logic [AMOUNT_WIDTH-1:0] disp_upd;

  // bit order {cancel, ok, erase, add}
  assign btn_cur  = {pnl.button_cancel_i, pnl.button_ok_i, pnl.button_erase_i, pnl.button_add_i};
  assign btn_rise = btn_cur & ~btn_q;

  // Scan downward so the lowest asserted switch is the one left standing.
  always_comb begin
    digit       = 4'd0;
    digit_valid = 1'b0;
    for (int i = SWITCH_COUNT - 1; i >= 0; i--) begin
      if (i < 10 && pnl.switches_i[i]) begin
        digit       = 4'(i);
        digit_valid = 1'b1;
      end
    end
  end

  assign disp_sum = {1'b0, disp_q} + SUM_W'(ML_PER_PULSE);

  always_comb begin
    disp_upd = disp_q;
    if (pnl.flow_pulse_i) begin
      if (disp_sum >= {1'b0, total_q}) disp_upd = total_q;
      else                             disp_upd = disp_sum[AMOUNT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    count_d   = count_q;
    disp_d    = disp_q;
    valve_d   = valve_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      ST_ENTRY: begin
        if (btn_rise[3]) begin
          total_d = '0;
          count_d = '0;
        end else if (btn_rise[2]) begin
          if (total_q != '0) begin
            state_d   = ST_DISPENSING;
            disp_d    = '0;
            valve_d   = 1'b1;
            busy_d    = 1'b1;
            aborted_d = 1'b0;
          end
        end else if (btn_rise[1]) begin
          if (count_q != 3'd0) begin
            total_d = total_q / AMOUNT_WIDTH'(10);
            count_d = count_q - 3'd1;
          end
        end else if (btn_rise[0]) begin
          if (digit_valid && count_q < 3'(MAXIMUM_DIGIT_COUNT)) begin
            total_d = total_q * AMOUNT_WIDTH'(10) + AMOUNT_WIDTH'(digit);
            count_d = count_q + 3'd1;
          end
        end
      end
      ST_DISPENSING: begin
        disp_d = disp_upd;
        if (btn_rise[3] || disp_upd >= total_q) begin
          state_d   = ST_ENTRY;
          total_d   = '0;
          count_d   = '0;
          valve_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = btn_rise[3];
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_ENTRY;
      btn_q     <= '1;
      total_q   <= '0;
      count_q   <= '0;
      disp_q    <= '0;
      valve_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_cur;
      total_q   <= total_d;
      count_q   <= count_d;
      disp_q    <= disp_d;
      valve_q   <= valve_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign pnl.total_amount_o     = total_q;
  assign pnl.digit_count_o      = count_q;
  assign pnl.dispensed_amount_o = disp_q;
  assign pnl.valve_open_o       = valve_q;
  assign pnl.busy_o             = busy_q;
  assign pnl.done_o             = done_q;
  assign pnl.aborted_o          = aborted_q;

endmodule

// File: tb/tb_water_dispenser_controller.sv
// Directed bench for the dispenser controller: entry, erase/cancel, dispense, abort, reset.
module tb_water_dispenser_controller;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  water_dispenser_controller_if #(.SWITCH_COUNT(10), .AMOUNT_WIDTH(14)) pnl_if ();

  water_dispenser_controller #(
    .SWITCH_COUNT(10), .MAXIMUM_DIGIT_COUNT(4), .AMOUNT_WIDTH(14), .ML_PER_PULSE(10)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .pnl     (pnl_if)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic add_digit(input int d);
    pnl_if.switches_i    = '0;
    pnl_if.switches_i[d] = 1'b1;
    pnl_if.button_add_i  = 1'b1;
    tick(1);
    pnl_if.button_add_i  = 1'b0;
    pnl_if.switches_i    = '0;
    tick(1);
  endtask

  // 0=add 1=erase 2=ok 3=cancel
  task automatic press(input int b);
    case (b)
      0: pnl_if.button_add_i    = 1'b1;
      1: pnl_if.button_erase_i  = 1'b1;
      2: pnl_if.button_ok_i     = 1'b1;
      default: pnl_if.button_cancel_i = 1'b1;
    endcase
    tick(1);
    pnl_if.button_add_i    = 1'b0;
    pnl_if.button_erase_i  = 1'b0;
    pnl_if.button_ok_i     = 1'b0;
    pnl_if.button_cancel_i = 1'b0;
    tick(1);
  endtask

  task automatic flow;
    pnl_if.flow_pulse_i = 1'b1;
    tick(1);
    pnl_if.flow_pulse_i = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " total"}, 32'(pnl_if.total_amount_o), 0);
    chk({tag, " count"}, 32'(pnl_if.digit_count_o), 0);
    chk({tag, " disp"},  32'(pnl_if.dispensed_amount_o), 0);
    chk({tag, " valve"}, 32'(pnl_if.valve_open_o), 0);
    chk({tag, " busy"},  32'(pnl_if.busy_o), 0);
    chk({tag, " done"},  32'(pnl_if.done_o), 0);
    chk({tag, " abort"}, 32'(pnl_if.aborted_o), 0);
  endtask

  initial begin
    pnl_if.switches_i      = '0;
    pnl_if.button_add_i    = 1'b0;
    pnl_if.button_erase_i  = 1'b0;
    pnl_if.button_ok_i     = 1'b0;
    pnl_if.button_cancel_i = 1'b0;
    pnl_if.flow_pulse_i    = 1'b0;
    tick(2);
    reset_i = 1'b0;
    tick(1);
    chk_idle("reset");

    add_digit(1); add_digit(2); add_digit(5);
    chk("enter125 total", 32'(pnl_if.total_amount_o), 125);
    chk("enter125 count", 32'(pnl_if.digit_count_o), 3);
    press(1);
    chk("erase total", 32'(pnl_if.total_amount_o), 12);
    chk("erase count", 32'(pnl_if.digit_count_o), 2);
    press(3);
    chk("cancel total", 32'(pnl_if.total_amount_o), 0);
    chk("cancel count", 32'(pnl_if.digit_count_o), 0);

    press(1);
    chk("erase empty count", 32'(pnl_if.digit_count_o), 0);
    pnl_if.switches_i = '0;
    press(0);
    chk("add noswitch total", 32'(pnl_if.total_amount_o), 0);
    chk("add noswitch count", 32'(pnl_if.digit_count_o), 0);
    pnl_if.switches_i = 10'b00_0010_0100;
    press(0);
    pnl_if.switches_i = '0;
    chk("lowest switch total", 32'(pnl_if.total_amount_o), 2);
    press(3);
    press(2);
    chk("ok zero busy", 32'(pnl_if.busy_o), 0);
    chk("ok zero valve", 32'(pnl_if.valve_open_o), 0);

    add_digit(9); add_digit(9); add_digit(9); add_digit(9); add_digit(7);
    chk("full total", 32'(pnl_if.total_amount_o), 9999);
    chk("full count", 32'(pnl_if.digit_count_o), 4);
    press(3);

    pnl_if.switches_i[3] = 1'b1;
    pnl_if.button_add_i  = 1'b1;
    tick(5);
    pnl_if.button_add_i  = 1'b0;
    pnl_if.switches_i    = '0;
    tick(1);
    chk("held add total", 32'(pnl_if.total_amount_o), 3);
    chk("held add count", 32'(pnl_if.digit_count_o), 1);
    pnl_if.button_cancel_i = 1'b1;
    tick(5);
    pnl_if.button_cancel_i = 1'b0;
    tick(1);
    chk("held cancel total", 32'(pnl_if.total_amount_o), 0);

    add_digit(2); add_digit(5);
    press(2);
    chk("disp25 busy", 32'(pnl_if.busy_o), 1);
    chk("disp25 valve", 32'(pnl_if.valve_open_o), 1);
    chk("disp25 start", 32'(pnl_if.dispensed_amount_o), 0);
    flow(); chk("disp25 p1", 32'(pnl_if.dispensed_amount_o), 10);
    chk("disp25 p1 done", 32'(pnl_if.done_o), 0);
    tick(1);
    flow(); chk("disp25 p2", 32'(pnl_if.dispensed_amount_o), 20);
    tick(1);
    flow();
    chk("disp25 sat", 32'(pnl_if.dispensed_amount_o), 25);
    chk("disp25 done", 32'(pnl_if.done_o), 1);
    chk("disp25 valve off", 32'(pnl_if.valve_open_o), 0);
    chk("disp25 busy off", 32'(pnl_if.busy_o), 0);
    chk("disp25 abort", 32'(pnl_if.aborted_o), 0);
    chk("disp25 total clr", 32'(pnl_if.total_amount_o), 0);
    tick(1);
    chk("disp25 done pulse", 32'(pnl_if.done_o), 0);
    flow(); tick(1);
    chk("entry flow ignored", 32'(pnl_if.dispensed_amount_o), 25);

    add_digit(1); add_digit(0); add_digit(0);
    chk("enter100", 32'(pnl_if.total_amount_o), 100);
    press(2);
    press(0); press(1); press(2);
    chk("disp frozen total", 32'(pnl_if.total_amount_o), 100);
    chk("disp frozen count", 32'(pnl_if.digit_count_o), 3);
    flow(); tick(1);
    flow(); tick(1);
    chk("abort pre", 32'(pnl_if.dispensed_amount_o), 20);
    pnl_if.button_cancel_i = 1'b1;
    pnl_if.flow_pulse_i    = 1'b1;
    tick(1);
    pnl_if.button_cancel_i = 1'b0;
    pnl_if.flow_pulse_i    = 1'b0;
    chk("abort disp", 32'(pnl_if.dispensed_amount_o), 30);
    chk("abort flag", 32'(pnl_if.aborted_o), 1);
    chk("abort done", 32'(pnl_if.done_o), 1);
    chk("abort valve", 32'(pnl_if.valve_open_o), 0);
    chk("abort busy", 32'(pnl_if.busy_o), 0);
    tick(1);
    chk("abort hold", 32'(pnl_if.aborted_o), 1);
    chk("abort done pulse", 32'(pnl_if.done_o), 0);
    chk("abort disp hold", 32'(pnl_if.dispensed_amount_o), 30);

    add_digit(5);
    pnl_if.button_ok_i = 1'b1;
    tick(1);
    chk("hold ok busy", 32'(pnl_if.busy_o), 1);
    chk("hold ok abort clr", 32'(pnl_if.aborted_o), 0);
    pnl_if.switches_i[7] = 1'b1;
    pnl_if.button_add_i  = 1'b1;
    reset_i = 1'b1;
    tick(1);
    chk_idle("mid reset");
    reset_i = 1'b0;
    tick(3);
    chk_idle("post reset held");
    pnl_if.button_ok_i  = 1'b0;
    pnl_if.button_add_i = 1'b0;
    pnl_if.switches_i   = '0;
    tick(1);
    add_digit(4);
    press(2);
    chk("repress busy", 32'(pnl_if.busy_o), 1);
    chk("repress valve", 32'(pnl_if.valve_open_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
